// File: rtl/song_pkg.sv
// Shared types and defaults for the song sequencer and its helpers.
package song_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF  = 6;

  // A zero duration marks an early end of song.
  localparam int END_MARKER = 0;

endpackage

// File: rtl/rom_wait_ctr.sv
// Down-counter that covers a fixed ROM read latency.
// valid stays high once the count reaches zero, until the next load.
module rom_wait_ctr #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic valid
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= CW'(LAT);
    end else if (load) begin
      cnt <= CW'(LAT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign valid = (cnt == '0);

endmodule

// File: rtl/song_sequencer.sv
// Walks a song ROM and hands one note at a time to the note player.
// Optional skip input is enabled with SONG_SEQUENCER_SKIP_EN.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SONG_AW   = 5,
  parameter int NOTE_W    = NOTE_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int ROM_LAT   = 1,
  localparam int SW       = $clog2(NUM_SONGS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic [SW-1:0]           song_sel,
  input  logic                    loop_mode,
  input  logic                    skip,
  input  logic                    note_done,
  output logic [SW+SONG_AW-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    new_note,
  output logic                    song_done,
  output logic [SW-1:0]           cur_song,
  output logic [1:0]              dbg_state
);

  // Handshake with the note player: new_note is a one-cycle strobe with
  // note/duration valid in that cycle; the player answers with a one-cycle
  // note_done pulse, honoured only in PLAY while play is high.

  state_e               state;
  logic [SONG_AW-1:0]   index;
  logic                 rom_valid;
  logic                 skip_act;
  logic                 is_marker;
  logic                 eos_fire;
  logic                 ctr_load;

`ifdef SONG_SEQUENCER_SKIP_EN
  assign skip_act = skip & play & (state != ST_IDLE);
`else
  logic skip_unused;
  assign skip_unused = skip;
  assign skip_act    = 1'b0;
`endif

  assign is_marker = (rom_data[DUR_W-1:0] == DUR_W'(END_MARKER));

  // Every way a song can end funnels through this one flag.
  assign eos_fire = play & (state != ST_IDLE) &
                    (skip_act |
                     ((state == ST_FETCH) & rom_valid & is_marker) |
                     ((state == ST_PLAY) & note_done & (index == '1)));

  assign ctr_load = (state != ST_FETCH) | eos_fire | (play & rom_valid);

  rom_wait_ctr #(.LAT(ROM_LAT)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ctr_load),
    .en      (play),
    .valid   (rom_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      index     <= '0;
      cur_song  <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= eos_fire;
      if (eos_fire) begin
        if (loop_mode) begin
          cur_song <= cur_song + 1'b1;
          index    <= '0;
          state    <= ST_FETCH;
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (play) begin
              cur_song <= song_sel;
              index    <= '0;
              state    <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (play && rom_valid) begin
              note     <= rom_data[NOTE_W+DUR_W-1:DUR_W];
              duration <= rom_data[DUR_W-1:0];
              new_note <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (play) state <= ST_PLAY;
          end
          ST_PLAY: begin
            if (play && note_done) begin
              index <= index + 1'b1;
              state <= ST_FETCH;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rom_addr  = {cur_song, index};
  assign dbg_state = state;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural ROM of ROM_LAT cycles.
module tb_song_sequencer;

  localparam int ROM_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic [1:0]  song_sel;
  logic        loop_mode;
  logic        skip;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;
  logic [1:0]  cur_song;
  logic [1:0]  dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  song_sequencer #(.ROM_LAT(ROM_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .song_sel  (song_sel),
    .loop_mode (loop_mode),
    .skip      (skip),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done),
    .cur_song  (cur_song),
    .dbg_state (dbg_state)
  );

  // ROM image: note = low address bits ^ 0x2A, duration = index+1,
  // with end markers at song 1 entry 3 (35) and song 3 entry 2 (98).
  function automatic logic [11:0] rom_word(input logic [6:0] a);
    logic [5:0] n;
    logic [5:0] d;
    n = a[5:0] ^ 6'h2A;
    d = {1'b0, a[4:0]} + 6'd1;
    if (a == 7'd35 || a == 7'd98) d = 6'd0;
    return {n, d};
  endfunction

  logic [11:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_word(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count cycles until new_note is seen, bounded.
  task automatic wait_nn(output int n);
    n = 0;
    while (new_note !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic play_note(input logic [6:0] a);
    int n;
    logic [11:0] w;
    w = rom_word(a);
    wait_nn(n);
    chk("nn_latency", n, ROM_LAT + 1);
    chk("note", {26'd0, note}, {26'd0, w[11:6]});
    chk("duration", {26'd0, duration}, {26'd0, w[5:0]});
    chk("no_done_with_nn", {31'd0, song_done}, 32'd0);
    step();
    chk("nn_one_cycle", {31'd0, new_note}, 32'd0);
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; play = 1'b0; song_sel = 2'd0; loop_mode = 1'b0;
    skip = 1'b0; note_done = 1'b0;
    step(); step();

    // Reset state
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    chk("rst_note", {26'd0, note}, 32'd0);
    chk("rst_duration", {26'd0, duration}, 32'd0);
    chk("rst_new_note", {31'd0, new_note}, 32'd0);
    chk("rst_song_done", {31'd0, song_done}, 32'd0);
    chk("rst_cur_song", {30'd0, cur_song}, 32'd0);

    // Start song 2, first entry, then advance
    reset_n = 1'b1;
    step();
    song_sel = 2'd2; play = 1'b1;
    step();
    chk("start_rom_addr", {25'd0, rom_addr}, 32'd64);
    chk("start_state", {30'd0, dbg_state}, 32'd1);
    chk("start_cur_song", {30'd0, cur_song}, 32'd2);
    play_note(7'd64);
    pulse_done();
    chk("adv_rom_addr", {25'd0, rom_addr}, 32'd65);
    chk("adv_state", {30'd0, dbg_state}, 32'd1);

    // Asynchronous reset in the middle of FETCH
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_note", {26'd0, note}, 32'd0);
    chk("mid_rst_duration", {26'd0, duration}, 32'd0);
    chk("mid_rst_cur_song", {30'd0, cur_song}, 32'd0);
    chk("mid_rst_new_note", {31'd0, new_note}, 32'd0);
    play = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Song 0, 32 entries, single play
    song_sel = 2'd0; loop_mode = 1'b0; play = 1'b1;
    step();
    for (int a = 0; a < 32; a++) begin
      play_note(7'(a));
      pulse_done();
    end
    chk("s0_song_done", {31'd0, song_done}, 32'd1);
    chk("s0_idle", {30'd0, dbg_state}, 32'd0);
    play = 1'b0;
    step();
    chk("s0_done_one_cycle", {31'd0, song_done}, 32'd0);
    chk("s0_stay_idle", {30'd0, dbg_state}, 32'd0);

    // Song 1 with an early end marker, loop mode
    song_sel = 2'd1; loop_mode = 1'b1; play = 1'b1;
    step();
    chk("s1_rom_addr", {25'd0, rom_addr}, 32'd32);
    for (int a = 32; a < 35; a++) begin
      play_note(7'(a));
      pulse_done();
    end
    chk("s1_marker_addr", {25'd0, rom_addr}, 32'd35);
    step(); step();
    chk("s1_song_done", {31'd0, song_done}, 32'd1);
    chk("s1_new_note", {31'd0, new_note}, 32'd0);
    chk("s1_next_song", {30'd0, cur_song}, 32'd2);
    chk("s1_next_addr", {25'd0, rom_addr}, 32'd64);
    play_note(7'd64);

    // Pause in PLAY; note_done while paused is ignored
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      note_done = (i == 3);
      step();
      chk("pause_state", {30'd0, dbg_state}, 32'd3);
      chk("pause_addr", {25'd0, rom_addr}, 32'd64);
      chk("pause_new_note", {31'd0, new_note}, 32'd0);
    end
    note_done = 1'b0;
    play = 1'b1;
    step(); step();
    chk("resume_state", {30'd0, dbg_state}, 32'd3);
    pulse_done();
    chk("resume_adv_addr", {25'd0, rom_addr}, 32'd65);

    // Rest of song 2, then song 3 ends early and wraps to song 0
    for (int a = 65; a < 96; a++) begin
      play_note(7'(a));
      pulse_done();
    end
    chk("s2_song_done", {31'd0, song_done}, 32'd1);
    chk("s2_next_song", {30'd0, cur_song}, 32'd3);
    chk("s2_next_addr", {25'd0, rom_addr}, 32'd96);
    play_note(7'd96);
    pulse_done();
    play_note(7'd97);
    pulse_done();
    step(); step();
    chk("s3_song_done", {31'd0, song_done}, 32'd1);
    chk("wrap_cur_song", {30'd0, cur_song}, 32'd0);
    chk("wrap_rom_addr", {25'd0, rom_addr}, 32'd0);

`ifdef SONG_SEQUENCER_SKIP_EN
    // Skip beats a simultaneous note_done
    play = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    song_sel = 2'd1; loop_mode = 1'b1; play = 1'b1;
    step();
    play_note(7'd32);
    skip = 1'b1; note_done = 1'b1;
    step();
    skip = 1'b0; note_done = 1'b0;
    chk("skip_song_done", {31'd0, song_done}, 32'd1);
    chk("skip_new_note", {31'd0, new_note}, 32'd0);
    chk("skip_cur_song", {30'd0, cur_song}, 32'd2);
    chk("skip_rom_addr", {25'd0, rom_addr}, 32'd64);
    play_note(7'd64);
`endif

    play = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
